axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI-lite-style single-beat memory slave sitting directly downstream of the IFU/LSU arbiter's master port.
- Holds a word-addressed on-chip array and serves one read and one write transaction at a time.
- The read and write channels run independently, each with a programmable response latency.
- Gives the arbiter and both masters realistic multi-cycle handshakes in simulation.

Parameters:
- AXI_DATA_WIDTH, 64, data bus width in bits; must be 32 or 64.
- AXI_ADDR_WIDTH, 64, address bus width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, write strobe width.
- MEM_WORDS, 4096, array depth in data words; power of two.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- READ_LAT, 2, wait cycles between AR handshake and R valid; 0..15.
- WRITE_LAT, 1, wait cycles between write capture and B valid; 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- axi_aw_ready_o  out  1  write address ready
- axi_aw_valid_i  in  1  write address valid
- axi_aw_addr_i  in  AXI_ADDR_WIDTH  write byte address
- axi_w_ready_o  out  1  write data ready
- axi_w_valid_i  in  1  write data valid
- axi_w_data_i  in  AXI_DATA_WIDTH  write data
- axi_w_strb_i  in  AXI_STRB_WIDTH  byte enables
- axi_b_ready_i  in  1  response ready
- axi_b_valid_o  out  1  response valid
- axi_b_resp_o  out  2  write response
- axi_ar_ready_o  out  1  read address ready
- axi_ar_valid_i  in  1  read address valid
- axi_ar_addr_i  in  AXI_ADDR_WIDTH  read byte address
- axi_r_ready_i  in  1  read data ready
- axi_r_valid_o  out  1  read data valid
- axi_r_resp_o  out  2  read response
- axi_r_data_o  out  AXI_DATA_WIDTH  read data

Behaviour:
- Reset: one clock, clk. rst is asynchronous, active-high.
  - While rst is high: both FSMs go to IDLE, counters clear, all outputs 0, and readies are forced 0.
  - The array is not reset.
  - Reset mid-transaction drops that transaction. A pending write that has not yet committed is not applied.
- Index and range:
  - index = (addr - BASE_ADDR) >> log2(AXI_STRB_WIDTH).
  - Low address bits are ignored.
  - An address is in range if BASE_ADDR <= addr < BASE_ADDR + MEM_WORDS*AXI_STRB_WIDTH.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: ar_ready=1. An AR handshake in cycle T latches the address and loads the counter with the latency.
    - Latency 0 goes straight to R_RESP.
    - Otherwise go to R_WAIT.
  - R_WAIT: counter decrements each cycle. On the cycle the counter reaches 1, the array is read and registered into r_data, and the FSM goes to R_RESP.
  - R_RESP: r_valid=1. r_data and r_resp stay stable until r_ready; then return to R_IDLE.
  - Timing: r_valid first asserts in cycle T+1+READ_LAT.
  - Back-to-back: a new AR is accepted no earlier than the cycle after the R handshake.
  - Out of range: r_resp=2'b11 (DECERR), r_data=0. Otherwise r_resp=2'b00.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: aw_ready=1 until AW is captured, and w_ready=1 until W is captured.
    - Either order is accepted, including the same cycle.
    - Once both are held, the counter loads WRITE_LAT and the FSM goes to W_WAIT, or to W_RESP if the latency is 0.
  - Commit: the write is applied to the array on the edge entering W_RESP, per byte, gated by strb. Strb 0 leaves that byte unchanged.
  - W_RESP: b_valid=1 until b_ready; then return to W_IDLE.
  - Timing: if the later of AW/W handshakes in cycle T, b_valid asserts in cycle T+1+WRITE_LAT.
  - Out of range: write dropped, b_resp=2'b11.
- Read/write collision: if a read samples the array on the same edge a write commits to the same index, the read returns the old data.
- Protocol rules:
  - Valid outputs never drop without a handshake.
  - Ready outputs do not depend combinationally on the matching valid.

Optional Feature:
- Macro: AXI_SRAM_RAND_LAT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 on reset, advances every cycle.
  - Each accepted transaction's latency = base parameter + lfsr[1:0], sampled at the AR handshake or at write capture.
- Undefined: latencies are fixed at READ_LAT / WRITE_LAT and no LFSR logic exists.

Decomposition:
- Package axi_sram_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - read and write state enums;
  - latency counter width (4).
- Sub-module lfsr16, used only under AXI_SRAM_RAND_LAT_EN.

Test Plan:
1. Write then read:
   - Stimulus: AW 0x8000_0008 and W 0x1122334455667788 strb 0xFF in the same cycle T; later AR 0x8000_0008.
   - Required: b_valid at T+2 with resp 00; r_data 0x1122334455667788, resp 00, r_valid at AR cycle+3.
2. Partial strobe:
   - Stimulus: preload 0xFFFF_FFFF_FFFF_FFFF, write 0 with strb 0x0F, then read.
   - Required: 0xFFFF_FFFF_0000_0000.
3. W before AW:
   - Stimulus: W handshake at cycle 5, AW at cycle 8.
   - Required: w_ready low cycles 6-8; b_valid at cycle 10.
4. R backpressure:
   - Stimulus: r_ready held low for 4 cycles.
   - Required: r_valid and r_data stable throughout; ar_ready stays 0 until the cycle after the R handshake.
5. Out of range:
   - Stimulus: AR 0x7FFF_FFF8 and a write to BASE_ADDR+MEM_WORDS*8.
   - Required: resp 2'b11, r_data 0, array unchanged.
6. Reset mid-operation:
   - Stimulus: assert rst during R_WAIT and during W_WAIT.
   - Required: r_valid/b_valid 0 immediately; readies 0 while rst is high; the pending write is absent on a later read.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// Shared constants and state types for the AXI-lite SRAM slave.
package axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of the per-channel response latency counter (latencies 0..15).
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/axi_sram_slave_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to jitter response latency.
// Only instantiated when AXI_SRAM_RAND_LAT_EN is defined.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift left, feedback from taps 16,14,13,11 into bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // State register, reseeded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-lite-style single-beat SRAM slave with independent read and write
// channels, each with a programmable response latency.
// Optional macro AXI_SRAM_RAND_LAT_EN adds lfsr[1:0] to each latency.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH = 64,
  parameter int          AXI_ADDR_WIDTH = 64,
  parameter int          AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int          MEM_WORDS      = 4096,
  parameter logic [63:0] BASE_ADDR      = 64'h8000_0000,
  parameter int          READ_LAT       = 2,
  parameter int          WRITE_LAT      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      axi_aw_ready_o,
  input  logic                      axi_aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_i,
  output logic                      axi_w_ready_o,
  input  logic                      axi_w_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_w_data_i,
  input  logic [AXI_STRB_WIDTH-1:0] axi_w_strb_i,
  input  logic                      axi_b_ready_i,
  output logic                      axi_b_valid_o,
  output logic [1:0]                axi_b_resp_o,
  output logic                      axi_ar_ready_o,
  input  logic                      axi_ar_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_i,
  input  logic                      axi_r_ready_i,
  output logic                      axi_r_valid_o,
  output logic [1:0]                axi_r_resp_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_r_data_o
);

  localparam int OFF_W = $clog2(AXI_STRB_WIDTH);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int HI    = IDX_W + OFF_W;
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE_A = AXI_ADDR_WIDTH'(BASE_ADDR);
`ifdef AXI_SRAM_RAND_LAT_EN
  // One extra bit so base latency plus jitter (up to 15+3) cannot wrap.
  localparam int CNT_W = LAT_CNT_W + 1;
`else
  localparam int CNT_W = LAT_CNT_W;
`endif

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------- latency source ----------------
  logic [CNT_W-1:0] r_lat, w_lat;
`ifdef AXI_SRAM_RAND_LAT_EN
  logic [15:0] lfsr;
  logic        lfsr_unused;
  lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );
  assign lfsr_unused = ^lfsr[15:2];
  assign r_lat = CNT_W'(READ_LAT)  + CNT_W'(lfsr[1:0]);
  assign w_lat = CNT_W'(WRITE_LAT) + CNT_W'(lfsr[1:0]);
`else
  assign r_lat = CNT_W'(READ_LAT);
  assign w_lat = CNT_W'(WRITE_LAT);
`endif

  // ---------------- address decode ----------------
  // A borrow out of (addr - base) means below range; any offset bit above
  // the index field means past the end. Byte-lane bits are ignored.
  logic [AXI_ADDR_WIDTH:0] ar_diff, aw_diff;
  logic                    ar_in_range, aw_in_range;
  logic [IDX_W-1:0]        ar_idx, aw_idx;
  logic                    addr_lsb_unused;

  // Offset, range flag and word index for both address channels.
  always_comb begin
    ar_diff         = {1'b0, axi_ar_addr_i} - {1'b0, BASE_A};
    aw_diff         = {1'b0, axi_aw_addr_i} - {1'b0, BASE_A};
    ar_in_range     = !ar_diff[AXI_ADDR_WIDTH] && (ar_diff[AXI_ADDR_WIDTH-1:HI] == '0);
    aw_in_range     = !aw_diff[AXI_ADDR_WIDTH] && (aw_diff[AXI_ADDR_WIDTH-1:HI] == '0);
    ar_idx          = ar_diff[HI-1:OFF_W];
    aw_idx          = aw_diff[HI-1:OFF_W];
    addr_lsb_unused = ^{ar_diff[OFF_W-1:0], aw_diff[OFF_W-1:0]};
  end

  // ---------------- read channel ----------------
  rd_state_e                 r_state_q, r_state_d;
  logic [CNT_W-1:0]          r_cnt_q, r_cnt_d;
  logic [IDX_W-1:0]          r_idx_q, r_idx_d;
  logic                      r_ok_q, r_ok_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]                r_resp_q, r_resp_d;
  logic                      rd_en, rd_ok;
  logic [IDX_W-1:0]          rd_idx;

  assign axi_ar_ready_o = (r_state_q == R_IDLE) && !rst;
  assign axi_r_valid_o  = (r_state_q == R_RESP);
  assign axi_r_data_o   = r_data_q;
  assign axi_r_resp_o   = r_resp_q;

  // Read next-state: accept AR, count down latency, sample array, hold response.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_idx_d   = r_idx_q;
    r_ok_d    = r_ok_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    rd_en     = 1'b0;
    rd_idx    = r_idx_q;
    rd_ok     = r_ok_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi_ar_valid_i && axi_ar_ready_o) begin
          r_idx_d = ar_idx;
          r_ok_d  = ar_in_range;
          r_cnt_d = r_lat;
          if (r_lat == '0) begin
            rd_en     = 1'b1;
            rd_idx    = ar_idx;
            rd_ok     = ar_in_range;
            r_state_d = R_RESP;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == CNT_W'(1)) begin
          rd_en     = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (axi_r_ready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    // Sampling the array before the edge gives old data on a same-edge write.
    if (rd_en) begin
      r_data_d = rd_ok ? mem[rd_idx] : '0;
      r_resp_d = rd_ok ? RESP_OKAY : RESP_DECERR;
    end
  end

  // Read channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
      r_ok_q    <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_idx_q   <= r_idx_d;
      r_ok_q    <= r_ok_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // ---------------- write channel ----------------
  wr_state_e                 w_state_q, w_state_d;
  logic [CNT_W-1:0]          w_cnt_q, w_cnt_d;
  logic                      aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [IDX_W-1:0]          aw_idx_q, aw_idx_d;
  logic                      aw_ok_q, aw_ok_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [1:0]                b_resp_q, b_resp_d;
  logic                      aw_hs, w_hs, mem_we, wr_ok;
  logic [IDX_W-1:0]          wr_idx;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [AXI_STRB_WIDTH-1:0] wr_strb;

  assign axi_aw_ready_o = (w_state_q == W_IDLE) && !aw_have_q && !rst;
  assign axi_w_ready_o  = (w_state_q == W_IDLE) && !w_have_q && !rst;
  assign axi_b_valid_o  = (w_state_q == W_RESP);
  assign axi_b_resp_o   = b_resp_q;
  assign aw_hs          = axi_aw_valid_i && axi_aw_ready_o;
  assign w_hs           = axi_w_valid_i && axi_w_ready_o;

  // Write next-state: collect AW and W in any order, wait, commit, respond.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    b_resp_d  = b_resp_q;
    mem_we    = 1'b0;
    // Held beat if already captured, else the one on the bus this cycle.
    wr_idx    = aw_have_q ? aw_idx_q : aw_idx;
    wr_ok     = aw_have_q ? aw_ok_q  : aw_in_range;
    wr_data   = w_have_q  ? wdata_q  : axi_w_data_i;
    wr_strb   = w_have_q  ? wstrb_q  : axi_w_strb_i;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          aw_idx_d  = aw_idx;
          aw_ok_d   = aw_in_range;
        end
        if (w_hs) begin
          w_have_d = 1'b1;
          wdata_d  = axi_w_data_i;
          wstrb_d  = axi_w_strb_i;
        end
        if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
          w_cnt_d  = w_lat;
          b_resp_d = wr_ok ? RESP_OKAY : RESP_DECERR;
          if (w_lat == '0) begin
            mem_we    = wr_ok;
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt_q == CNT_W'(1)) begin
          mem_we    = wr_ok;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (axi_b_ready_i) begin
          w_state_d = W_IDLE;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // Byte-masked array commit on the edge entering W_RESP; array is not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized scoreboard bench for axi_sram_slave (default build).
module tb_axi_sram_slave;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          WORDS = 4096;
  localparam logic [63:0] LIM   = BASE + 64'(WORDS) * 64'd8;
  localparam int          RL    = 2;
  localparam int          WL    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        axi_aw_ready_o, axi_aw_valid_i;
  logic [63:0] axi_aw_addr_i;
  logic        axi_w_ready_o, axi_w_valid_i;
  logic [63:0] axi_w_data_i;
  logic [7:0]  axi_w_strb_i;
  logic        axi_b_ready_i, axi_b_valid_o;
  logic [1:0]  axi_b_resp_o;
  logic        axi_ar_ready_o, axi_ar_valid_i;
  logic [63:0] axi_ar_addr_i;
  logic        axi_r_ready_i, axi_r_valid_o;
  logic [1:0]  axi_r_resp_o;
  logic [63:0] axi_r_data_o;

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .axi_aw_ready_o(axi_aw_ready_o), .axi_aw_valid_i(axi_aw_valid_i), .axi_aw_addr_i(axi_aw_addr_i),
    .axi_w_ready_o(axi_w_ready_o), .axi_w_valid_i(axi_w_valid_i), .axi_w_data_i(axi_w_data_i),
    .axi_w_strb_i(axi_w_strb_i), .axi_b_ready_i(axi_b_ready_i), .axi_b_valid_o(axi_b_valid_o),
    .axi_b_resp_o(axi_b_resp_o), .axi_ar_ready_o(axi_ar_ready_o), .axi_ar_valid_i(axi_ar_valid_i),
    .axi_ar_addr_i(axi_ar_addr_i), .axi_r_ready_i(axi_r_ready_i), .axi_r_valid_o(axi_r_valid_o),
    .axi_r_resp_o(axi_r_resp_o), .axi_r_data_o(axi_r_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          cyc;
  } exp_t;

  exp_t        rq[$];
  exp_t        bq[$];
  logic [63:0] mdl [int];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          bp_en = 0;
  bit          r_hold = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < LIM);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  // Ready generators: always ready, random backpressure, or held low.
  initial begin
    axi_r_ready_i = 1'b0;
    axi_b_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      axi_r_ready_i = r_hold ? 1'b0 : (bp_en ? ($urandom_range(0, 2) != 0) : 1'b1);
      axi_b_ready_i = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every R/B handshake, checks first-valid
  // timing, stability under backpressure, and ready behaviour around responses.
  initial begin
    bit r_act = 0, b_act = 0, r_hs_prev = 0, b_hs_prev = 0;
    logic [63:0] r_first;
    logic [1:0]  r_first_resp;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_act = 0; b_act = 0; r_hs_prev = 0; b_hs_prev = 0;
      end else begin
        if (r_hs_prev) chk("ar_ready_after_r", axi_ar_ready_o, 1);
        r_hs_prev = 0;
        if (axi_r_valid_o) begin
          if (rq.size() == 0) fail_now("r_valid_unexpected");
          else begin
            chk("ar_ready_while_r", axi_ar_ready_o, 0);
            if (!r_act) begin
              chk("r_latency", 64'(cyc), 64'(rq[0].cyc));
              r_act = 1; r_first = axi_r_data_o; r_first_resp = axi_r_resp_o;
            end else begin
              chk("r_data_stable", axi_r_data_o, r_first);
              chk("r_resp_stable", 64'(axi_r_resp_o), 64'(r_first_resp));
            end
            if (axi_r_ready_i) begin
              chk("r_data", axi_r_data_o, rq[0].data);
              chk("r_resp", 64'(axi_r_resp_o), 64'(rq[0].resp));
              void'(rq.pop_front());
              r_act = 0; r_hs_prev = 1;
            end
          end
        end
        if (b_hs_prev) chk("aw_w_ready_after_b", 64'({axi_aw_ready_o, axi_w_ready_o}), 64'd3);
        b_hs_prev = 0;
        if (axi_b_valid_o) begin
          if (bq.size() == 0) fail_now("b_valid_unexpected");
          else begin
            chk("aw_w_ready_while_b", 64'({axi_aw_ready_o, axi_w_ready_o}), 64'd0);
            if (!b_act) begin
              chk("b_latency", 64'(cyc), 64'(bq[0].cyc));
              b_act = 1;
            end
            if (axi_b_ready_i) begin
              chk("b_resp", 64'(axi_b_resp_o), 64'(bq[0].resp));
              void'(bq.pop_front());
              b_act = 0; b_hs_prev = 1;
            end
          end
        end
      end
    end
  end

  task automatic do_read(input logic [63:0] addr);
    exp_t e;
    int   t = -1;
    @(posedge clk); #1;
    axi_ar_valid_i = 1'b1;
    axi_ar_addr_i  = addr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi_ar_ready_o) begin
        t      = cyc;
        e.data = in_rng(addr) ? mdl[widx(addr)] : 64'd0;
        e.resp = in_rng(addr) ? 2'b00 : 2'b11;
        e.cyc  = t + 1 + RL;
        rq.push_back(e);
        @(posedge clk); #1;
        axi_ar_valid_i = 1'b0;
        break;
      end
      @(posedge clk);
    end
    if (t < 0) begin
      fail_now("ar_handshake_timeout");
      axi_ar_valid_i = 1'b0;
    end
  endtask

  // da/dw: idle cycles before AW / W are presented.
  task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input int da, input int dw);
    exp_t e;
    int   taw = -1, tw = -1;
    fork
      begin
        repeat (da) @(posedge clk);
        @(posedge clk); #1;
        axi_aw_valid_i = 1'b1;
        axi_aw_addr_i  = addr;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (axi_aw_ready_o) begin
            taw = cyc;
            @(posedge clk); #1;
            axi_aw_valid_i = 1'b0;
            break;
          end
          @(posedge clk);
        end
        for (int k = 0; k < 60 && taw >= 0 && tw < 0; k++) begin
          @(negedge clk);
          if (tw < 0) chk("aw_ready_low_after_aw", axi_aw_ready_o, 0);
        end
      end
      begin
        repeat (dw) @(posedge clk);
        @(posedge clk); #1;
        axi_w_valid_i = 1'b1;
        axi_w_data_i  = data;
        axi_w_strb_i  = strb;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (axi_w_ready_o) begin
            tw = cyc;
            @(posedge clk); #1;
            axi_w_valid_i = 1'b0;
            break;
          end
          @(posedge clk);
        end
        for (int k = 0; k < 60 && tw >= 0 && taw < 0; k++) begin
          @(negedge clk);
          if (taw < 0) chk("w_ready_low_after_w", axi_w_ready_o, 0);
        end
      end
    join
    if (taw < 0 || tw < 0) begin
      fail_now("aw_w_handshake_timeout");
      axi_aw_valid_i = 1'b0;
      axi_w_valid_i  = 1'b0;
    end else begin
      e.data = '0;
      e.resp = in_rng(addr) ? 2'b00 : 2'b11;
      e.cyc  = ((taw > tw) ? taw : tw) + 1 + WL;
      bq.push_back(e);
      if (in_rng(addr)) begin
        logic [63:0] w = mdl.exists(widx(addr)) ? mdl[widx(addr)] : 64'd0;
        for (int b = 0; b < 8; b++) if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
        mdl[widx(addr)] = w;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (rq.size() != 0 || bq.size() != 0); i++) @(posedge clk);
    if (rq.size() != 0 || bq.size() != 0) begin
      fail_now("response_timeout");
      rq.delete();
      bq.delete();
    end
  endtask

  initial begin
    logic [63:0] a;
    rst = 1'b1;
    axi_aw_valid_i = 0; axi_aw_addr_i = '0;
    axi_w_valid_i = 0;  axi_w_data_i = '0; axi_w_strb_i = '0;
    axi_ar_valid_i = 0; axi_ar_addr_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ar_ready", axi_ar_ready_o, 0);
    chk("rst_aw_ready", axi_aw_ready_o, 0);
    chk("rst_w_ready", axi_w_ready_o, 0);
    chk("rst_r_valid", axi_r_valid_o, 0);
    chk("rst_b_valid", axi_b_valid_o, 0);
    chk("rst_r_data", axi_r_data_o, 0);
    chk("rst_resps", 64'({axi_r_resp_o, axi_b_resp_o}), 0);
    rst = 1'b0;

    // Preload the working window (words 0..15).
    for (int i = 0; i < 16; i++) begin
      do_write(BASE + 64'(i) * 8, {$urandom, $urandom}, 8'hFF,
               $urandom_range(0, 2), $urandom_range(0, 2));
      drain();
    end

    // Write then read, AW and W in the same cycle.
    do_write(64'h8000_0008, 64'h1122334455667788, 8'hFF, 0, 0); drain();
    do_read(64'h8000_0008); drain();

    // Partial strobe.
    do_write(64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0); drain();
    do_write(64'h8000_0010, 64'h0, 8'h0F, 0, 0); drain();
    do_read(64'h8000_0010); drain();
    chk("partial_strobe_model", mdl[2], 64'hFFFF_FFFF_0000_0000);

    // W three cycles before AW.
    do_write(64'h8000_0018, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 3, 0); drain();
    do_read(64'h8000_0018); drain();

    // R backpressure for 4 cycles.
    r_hold = 1;
    do_read(64'h8000_0020);
    for (int i = 0; i < 50 && !axi_r_valid_o; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    r_hold = 0;
    drain();

    // Out of range on both sides.
    do_read(64'h7FFF_FFF8); drain();
    do_write(LIM, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 0); drain();
    do_read(BASE); drain();
    do_read(LIM + 64'h40); drain();

    // Random traffic with backpressure, low address bits set at random.
    bp_en = 1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 64'(($urandom_range(1, 4)) * 8);
        1:       a = LIM + 64'(($urandom_range(0, 4)) * 8);
        default: a = BASE + 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 1) == 0) do_read(a);
      else do_write(a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      drain();
    end
    bp_en = 0;

    // Reset while both channels are waiting: nothing responds, write is lost.
    @(posedge clk); #1;
    axi_ar_valid_i = 1; axi_ar_addr_i = BASE + 40;
    axi_aw_valid_i = 1; axi_aw_addr_i = BASE + 40;
    axi_w_valid_i = 1;  axi_w_data_i = ~mdl[5]; axi_w_strb_i = 8'hFF;
    @(negedge clk);
    chk("pre_rst_readies", 64'({axi_ar_ready_o, axi_aw_ready_o, axi_w_ready_o}), 64'd7);
    @(posedge clk); #1;
    axi_ar_valid_i = 0; axi_aw_valid_i = 0; axi_w_valid_i = 0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valids", 64'({axi_r_valid_o, axi_b_valid_o}), 0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_readies", 64'({axi_ar_ready_o, axi_aw_ready_o, axi_w_ready_o}), 0);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    do_read(BASE + 40); drain();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
